// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the iterative shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = 5;
    localparam logic [MULT_CNT_W-1:0] MULT_LAST_ITER = 5'd31;

endpackage

// File: rtl/shift_add_mult_cia.sv
// shift_add_mult_cia: carry-increment adder; each block adds with zero carry-in,
// then increments its partial sum when the block below produces a carry.
module shift_add_mult_cia #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH/BLK:0] c;

    assign c[0] = 1'b0;

    for (genvar k = 0; k < WIDTH / BLK; k++) begin : g_blk
        logic [BLK:0] raw;
        assign raw = {1'b0, a[k*BLK +: BLK]} + {1'b0, b[k*BLK +: BLK]};
        assign sum[k*BLK +: BLK] = raw[BLK-1:0] + {{(BLK-1){1'b0}}, c[k]};
        // An all-ones partial sum turns an incoming carry into an outgoing one.
        assign c[k+1] = raw[BLK] | (c[k] & (&raw[BLK-1:0]));
    end

    assign cout = c[WIDTH/BLK];

endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: 32x32 unsigned iterative multiplier, one add-and-shift per cycle,
// valid/ready handshakes on operands and on the 64-bit product.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    mult_state_t           state_q, state_d;
    logic [WIDTH-1:0]      a_q, hi_q, lo_q;
    logic [MULT_CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0]      addend, s;
    logic                  c, accept, last, finish;

    assign addend = lo_q[0] ? a_q : '0;

    shift_add_mult_cia #(.WIDTH(WIDTH)) u_cia (
        .a    (hi_q),
        .b    (addend),
        .sum  (s),
        .cout (c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        accept    = in_ready & in_valid;
        last      = (state_q == RUN) && (cnt_q == MULT_LAST_ITER);
        finish    = out_valid & out_ready;
        state_d   = accept ? RUN : last ? DONE : finish ? IDLE : state_q;
    end

    // Carry-out re-enters as the accumulator MSB, so no product bit is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= in_a;
            hi_q  <= '0;
            lo_q  <= in_b;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            hi_q  <= {c, s[WIDTH-1:1]};
            lo_q  <= {s[0], lo_q[WIDTH-1:1]};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign product = {hi_q, lo_q};

endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed vectors with hand-computed products, latency,
// backpressure, mid-run reset and ignored-input checks.
module tb_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    shift_add_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        check("accept_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_ready", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd32);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", 64'(out_valid), 64'd0);
        check("post_hs_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_product", product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(32'd3, 32'd5);
        wait_done("small");
        check("small_product", product, 64'h0000_0000_0000_000F);
        handshake();

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("max");
        check("max_product", product, 64'hFFFF_FFFE_0000_0001);
        handshake();

        start_op(32'd0, 32'hDEAD_BEEF);
        wait_done("zero");
        check("zero_product", product, 64'd0);
        handshake();

        start_op(32'h1234_5678, 32'h9ABC_DEF0);
        wait_done("bp");
        for (int i = 0; i < 10; i++) begin
            check("bp_product", product, 64'h0B00_EA4E_242D_2080);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        handshake();

        start_op(32'hCAFE_F00D, 32'h0BAD_F00D);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_product", product, 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        start_op(32'd7, 32'd6);
        wait_done("post_rst");
        check("post_rst_product", product, 64'd42);
        handshake();

        in_a = 32'd100;
        in_b = 32'd200;
        in_valid = 1'b1;
        @(negedge clk);
        begin
            int cyc = 0;
            while (!out_valid && cyc < 100) begin
                check("ign_run_ready", 64'(in_ready), 64'd0);
                in_a = $urandom;
                in_b = $urandom;
                @(negedge clk);
                cyc++;
            end
            check("ign_latency", 64'(cyc), 64'd32);
        end
        check("ign_product", product, 64'd20000);
        repeat (3) begin
            in_a = $urandom;
            in_b = $urandom;
            @(negedge clk);
            check("ign_done_ready", 64'(in_ready), 64'd0);
            check("ign_done_product", product, 64'd20000);
        end
        in_a = 32'd9;
        in_b = 32'd11;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_no_accept_ready", 64'(in_ready), 64'd1);
        check("hs_no_accept_valid", 64'(out_valid), 64'd0);
        check("stale_product", product, 64'd20000);
        @(negedge clk);
        in_valid = 1'b0;
        check("next_accept_ready", 64'(in_ready), 64'd0);
        wait_done("next");
        check("next_product", product, 64'd99);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
